encrypt_arbiter: RTL and testbench

Sequencing controller and two-port arbiter that shares one 128-bit `encryptor` core between two requesters. Each requester hands over a plaintext/key pair with a valid/ready handshake. The block registers the pair, pulses the core's load/`rst` input, and waits for `done`. It then returns the ciphertext, tagged with the requester id, on a single valid/ready response channel. Arbitration is round-robin, and an optional watchdog aborts a stuck core.

---
 rtl/encrypt_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_encrypt_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/encrypt_arbiter.sv
// encrypt_arbiter: round-robin sequencer sharing one 128-bit encryptor core between two requesters.
// Defining ENCRYPT_ARBITER_TIMEOUT_EN adds a RUN watchdog that aborts after TIMEOUT cycles.
module encrypt_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_plaintext,
  input  logic [127:0] req0_key,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_plaintext,
  input  logic [127:0] req1_key,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_id,
  output logic [127:0] resp_ciphertext,
  output logic         resp_err,
  output logic         busy,
  output logic [127:0] enc_plaintext,
  output logic [127:0] enc_key,
  output logic         enc_rst,
  input  logic [127:0] enc_ciphertext,
  input  logic         enc_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   last_id;
  logic   grant_valid;
  logic   grant_id;
  logic   accept;
  logic   run_armed;
  logic   done_hit;
  logic   timeout_hit;
  logic   resp_hs;

  // run_armed is low during the first RUN cycle so a stale done from the previous job is ignored
  assign done_hit = (state == RUN) && run_armed && enc_done;
  assign resp_hs  = (state == RESP) && resp_ready;
  assign accept   = (req0_valid && req0_ready) || (req1_valid && req1_ready);

`ifdef ENCRYPT_ARBITER_TIMEOUT_EN
  localparam logic [7:0] RUN_LAST = 8'(TIMEOUT - 1);

  logic [7:0] run_cnt;
  logic       err_flag;

  // RUN cycle counter: cleared outside RUN, so it restarts from zero on every entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_cnt <= 8'd0;
    end else if (state == RUN) begin
      run_cnt <= run_cnt + 8'd1;
    end else begin
      run_cnt <= 8'd0;
    end
  end

  assign timeout_hit = (state == RUN) && (run_cnt == RUN_LAST);

  // Error flag: done has priority over a coincident timeout
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_flag <= 1'b0;
    end else if (done_hit) begin
      err_flag <= 1'b0;
    end else if (timeout_hit) begin
      err_flag <= 1'b1;
    end else if (accept) begin
      err_flag <= 1'b0;
    end else begin
      err_flag <= err_flag;
    end
  end

  assign resp_err = err_flag;
`else
  logic unused_timeout;
  assign unused_timeout = ^(8'(TIMEOUT));
  assign timeout_hit    = 1'b0;
  assign resp_err       = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = LOAD;
        end else begin
          state_nxt = IDLE;
        end
      end
      LOAD: state_nxt = RUN;
      RUN: begin
        if (done_hit || timeout_hit) begin
          state_nxt = RESP;
        end else begin
          state_nxt = RUN;
        end
      end
      RESP: begin
        if (resp_hs) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = RESP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant and request-ready outputs; a tie goes to the requester not served last
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = ~last_id;
      end else if (req0_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b0;
      end else if (req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b1;
      end else begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
      end
    end else begin
      grant_valid = 1'b0;
      grant_id    = 1'b0;
    end
    req0_ready = rst && grant_valid && !grant_id;
    req1_ready = rst && grant_valid && grant_id;
  end

  // Operand capture, registered control outputs and response datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enc_plaintext   <= 128'd0;
      enc_key         <= 128'd0;
      resp_id         <= 1'b0;
      resp_ciphertext <= 128'd0;
      resp_valid      <= 1'b0;
      enc_rst         <= 1'b0;
      busy            <= 1'b0;
      run_armed       <= 1'b0;
      last_id         <= 1'b1;
    end else begin
      if (accept) begin
        enc_plaintext <= grant_id ? req1_plaintext : req0_plaintext;
        enc_key       <= grant_id ? req1_key : req0_key;
        resp_id       <= grant_id;
      end
      if (done_hit) begin
        resp_ciphertext <= enc_ciphertext;
      end else if (timeout_hit) begin
        resp_ciphertext <= 128'd0;
      end
      if (resp_hs) begin
        last_id <= resp_id;
      end
      resp_valid <= (state_nxt == RESP);
      enc_rst    <= (state_nxt == LOAD);
      busy       <= (state_nxt != IDLE);
      run_armed  <= (state == RUN);
    end
  end

endmodule

// File: tb/tb_encrypt_arbiter.sv
// Directed self-checking bench for encrypt_arbiter with a behavioural stand-in for the encryptor core.
module tb_encrypt_arbiter;

  localparam logic [127:0] PT_A  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] KEY_A = 128'h0f1571c947d9e8590cb7add6af7f6798;
  localparam logic [127:0] CT_A  = 128'hff0b844a0853bf7c6934ab4364148fb9;
  localparam logic [127:0] PT_B  = 128'h636f6d7061726368636f6d7061726368;
  localparam logic [127:0] KEY_B = 128'h6772696666696e746772696666696e74;
  localparam logic [127:0] CT_B  = 128'h27a15792bba1cb6cba23475fdaa1cb1a;
  localparam logic [127:0] PT_C  = 128'h000000000000000000000000000000f0;
  localparam logic [127:0] KEY_C = 128'h0000000000000000000000000000000f;
  localparam logic [127:0] CT_C  = 128'h000000000000000000000000000000ff;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [127:0] req0_plaintext, req0_key, req1_plaintext, req1_key;
  logic         resp_valid, resp_ready, resp_id, resp_err, busy;
  logic [127:0] resp_ciphertext, enc_plaintext, enc_key, enc_ciphertext;
  logic         enc_rst, enc_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rst_hi = 0;
  int mode = 0;  // 0: core done after a few cycles, 1: done tied high, 2: never done

  logic [127:0] core_ct = 128'd0;
  logic         core_done = 1'b0;
  int           core_cnt = 0;

  encrypt_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_plaintext(req0_plaintext), .req0_key(req0_key),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_plaintext(req1_plaintext), .req1_key(req1_key),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_ciphertext(resp_ciphertext), .resp_err(resp_err), .busy(busy),
    .enc_plaintext(enc_plaintext), .enc_key(enc_key), .enc_rst(enc_rst),
    .enc_ciphertext(enc_ciphertext), .enc_done(enc_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (enc_rst) rst_hi <= rst_hi + 1;

  // Known AES vectors stand in for the real core; other operands map to pt ^ key
  function automatic logic [127:0] ref_ct(input logic [127:0] pt, input logic [127:0] k);
    if (pt == PT_A && k == KEY_A) return CT_A;
    else if (pt == PT_B && k == KEY_B) return CT_B;
    else return pt ^ k;
  endfunction

  always @(posedge clk) begin
    if (enc_rst) begin
      core_cnt  <= 4;
      core_done <= 1'b0;
    end else if (core_cnt > 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1) begin
        core_done <= 1'b1;
        core_ct   <= ref_ct(enc_plaintext, enc_key);
      end
    end
  end

  assign enc_done       = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : core_done;
  assign enc_ciphertext = (mode == 0) ? core_ct : ref_ct(enc_plaintext, enc_key);

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic get_grant(output logic gid, output int e0);
    bit hit = 1'b0;
    gid = 1'b0;
    e0  = 0;
    for (int i = 0; i < 20; i++) begin
      if (!hit) begin
        #1;
        if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
          hit = 1'b1;
          gid = req1_ready;
          e0  = cyc + 1;
        end else begin
          @(negedge clk);
        end
      end
    end
    check("grant_seen", 128'(hit), 128'd1);
  endtask

  task automatic wait_resp(input int e0, output int lat);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!ok) begin
        @(negedge clk);
        ok = resp_valid;
      end
    end
    lat = cyc - e0;
    check("resp_seen", 128'(ok), 128'd1);
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  // One request from a single requester, through to the response (not consumed)
  task automatic single(input logic id, input logic [127:0] pt, input logic [127:0] key, output int lat);
    logic gid;
    int   e0;
    int   r0;
    r0 = rst_hi;
    if (id) begin
      req1_plaintext = pt; req1_key = key; req1_valid = 1'b1;
    end else begin
      req0_plaintext = pt; req0_key = key; req0_valid = 1'b1;
    end
    get_grant(gid, e0);
    check("single_grant", 128'(gid), 128'(id));
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("load_pulse", 128'(enc_rst), 128'd1);
    check("load_busy", 128'(busy), 128'd1);
    wait_resp(e0, lat);
    check("enc_rst_cycles", 128'(rst_hi - r0), 128'd1);
    check("resp_id", 128'(resp_id), 128'(id));
  endtask

  // Both requesters valid together; serve both, optionally stalling the first response
  task automatic tie_pair(input logic first_id, input bit stall);
    logic         gid;
    logic         other;
    int           e0;
    int           lat;
    logic [127:0] ct_first;
    other = ~first_id;
    ct_first = first_id ? CT_B : CT_A;
    req0_plaintext = PT_A; req0_key = KEY_A; req0_valid = 1'b1;
    req1_plaintext = PT_B; req1_key = KEY_B; req1_valid = 1'b1;
    get_grant(gid, e0);
    check("tie_grant", 128'(gid), 128'(first_id));
    @(negedge clk);
    if (gid) req1_valid = 1'b0;
    else req0_valid = 1'b0;
    wait_resp(e0, lat);
    check("tie_id1", 128'(resp_id), 128'(first_id));
    check("tie_ct1", resp_ciphertext, ct_first);
    if (stall) begin
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        check("bp_valid", 128'(resp_valid), 128'd1);
        check("bp_id", 128'(resp_id), 128'(first_id));
        check("bp_ct", resp_ciphertext, ct_first);
        check("bp_ready", 128'({req0_ready, req1_ready}), 128'd0);
      end
    end
    handshake();
    #1;
    check("next_ready", 128'(other ? req1_ready : req0_ready), 128'd1);
    get_grant(gid, e0);
    check("tie_grant2", 128'(gid), 128'(other));
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_resp(e0, lat);
    check("tie_id2", 128'(resp_id), 128'(other));
    check("tie_ct2", resp_ciphertext, other ? CT_B : CT_A);
    handshake();
  endtask

  initial begin
    #100000;
    $display("FAIL bench_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lat;
    int seen;
    logic gid;
    int e0;
    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
    req0_plaintext = 128'd0; req0_key = 128'd0; req1_plaintext = 128'd0; req1_key = 128'd0;
    repeat (3) @(negedge clk);
    req0_valid = 1'b1;
    #1;
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_resp_valid", 128'(resp_valid), 128'd0);
    check("rst_enc_rst", 128'(enc_rst), 128'd0);
    check("rst_ready", 128'({req0_ready, req1_ready}), 128'd0);
    check("rst_ct", resp_ciphertext, 128'd0);
    check("rst_enc_pt", enc_plaintext, 128'd0);
    check("rst_err", 128'(resp_err), 128'd0);
    req0_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Single request from requester 0
    single(1'b0, PT_A, KEY_A, lat);
    check("single_ct", resp_ciphertext, CT_A);
    check("single_err", 128'(resp_err), 128'd0);
    handshake();
    check("after_hs_valid", 128'(resp_valid), 128'd0);
    check("enc_pt_hold", enc_plaintext, PT_A);

    // req0 was served last, so a tie now goes to req1; first response is stalled
    tie_pair(1'b1, 1'b1);

    // Fresh reset: req0 wins the first tie, then round-robin grants req0 again after req1
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tie_pair(1'b0, 1'b0);
    tie_pair(1'b0, 1'b0);

    // Minimum latency with done stuck high
    mode = 1;
    single(1'b0, PT_C, KEY_C, lat);
    check("min_latency", 128'(lat), 128'd3);
    check("min_ct", resp_ciphertext, CT_C);
    handshake();
    mode = 0;

`ifdef ENCRYPT_ARBITER_TIMEOUT_EN
    mode = 2;
    single(1'b1, PT_B, KEY_B, lat);
    check("wd_latency", 128'(lat), 128'd9);
    check("wd_err", 128'(resp_err), 128'd1);
    check("wd_ct", resp_ciphertext, 128'd0);
    handshake();
    mode = 0;
`endif

    // Reset asserted while the core is running
    mode = 2;
    req0_plaintext = PT_A; req0_key = KEY_A; req0_valid = 1'b1;
    get_grant(gid, e0);
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_busy", 128'(busy), 128'd0);
    check("mid_enc_rst", 128'(enc_rst), 128'd0);
    check("mid_resp_valid", 128'(resp_valid), 128'd0);
    check("mid_enc_pt", enc_plaintext, 128'd0);
    check("mid_ct", resp_ciphertext, 128'd0);
    mode = 0;
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    check("mid_no_resp", 128'(seen), 128'd0);
    single(1'b1, PT_B, KEY_B, lat);
    check("post_rst_ct", resp_ciphertext, CT_B);
    handshake();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
